sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/systolic_pkg.sv | 14 +
 rtl/sram_port_arbiter_rr_pick.sv | 27 ++
 rtl/sram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared arbiter types: FSM state encoding and fixed requester identifiers.
package systolic_pkg;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    localparam int unsigned REQ_HOST = 0;
    localparam int unsigned REQ_A    = 1;
    localparam int unsigned REQ_B    = 2;
    localparam int unsigned REQ_C    = 3;

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Wrap-around priority picker: first valid index at or after ptr, modulo N.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!any && valid[idx]) begin
                winner = W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin SRAM port arbiter with locked bursts and a 2-stage read-ID pipeline.
module sram_port_arbiter
    import systolic_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned ADDR_WIDTH = 10,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MAX_BURST  = 16,
    localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    arb_state_t             state, state_nxt;
    logic [ID_W-1:0]        owner, owner_nxt;
    logic [ID_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]       burst_cnt, burst_cnt_nxt;
    logic [ID_W-1:0]        winner;
    logic                   any_valid;
    logic                   fire;
    logic                   p1_valid, p2_valid;
    logic [ID_W-1:0]        p1_id, p2_id;
    logic [DATA_WIDTH-1:0]  rdata_hold;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_valid)
    );

    // Next-state, grant and handshake decode.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        req_ready     = '0;
        fire          = 1'b0;
        case (state)
            ARB: begin
                if (any_valid) begin
                    state_nxt     = OWN;
                    owner_nxt     = winner;
                    rr_ptr_nxt    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    burst_cnt_nxt = '0;
                end
            end
            OWN: begin
                req_ready[owner] = 1'b1;
                fire             = req_valid[owner];
                if (!req_valid[owner]) begin
                    state_nxt = ARB;
                end else if (!req_lock[owner] || burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                    state_nxt = ARB;
                end else begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            owner     <= ID_W'(REQ_HOST);
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Register the owner's command toward the SRAM; address/data hold between fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= fire;
            mem_we <= fire & req_we[owner];
            if (fire) begin
                mem_addr  <= req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata <= req_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Carry the reader's ID alongside the SRAM latency so responses route after ownership moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid   <= 1'b0;
            p1_id      <= '0;
            p2_valid   <= 1'b0;
            p2_id      <= '0;
            rdata_hold <= '0;
        end else begin
            p1_valid <= fire & ~req_we[owner];
            p1_id    <= owner;
            p2_valid <= p1_valid;
            p2_id    <= p1_id;
            if (p2_valid) begin
                rdata_hold <= mem_rdata;
            end
        end
    end

    // Response strobe and data: live SRAM data on the response cycle, held value otherwise.
    always_comb begin
        rsp_valid = '0;
        if (p2_valid) begin
            rsp_valid[p2_id] = 1'b1;
        end
        rsp_rdata = p2_valid ? mem_rdata : rdata_hold;
    end

    assign grant_id = owner;
    assign busy     = (state == OWN) | p1_valid | p2_valid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: cycle model of the arbitration rules plus directed scenario checks.
module tb_sram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic [1:0]      grant_id;
    logic            busy;

    sram_port_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        return 32'hA000_0000 | 32'(a);
    endfunction

    // SRAM stub: one-cycle read latency; unwritten words return a fixed address pattern.
    logic [31:0] sram [1024];
    bit          wrt  [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                sram[mem_addr] <= mem_wdata;
                wrt[mem_addr]  <= 1'b1;
            end else begin
                mem_rdata <= wrt[mem_addr] ? sram[mem_addr] : pat(mem_addr);
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model state
    bit          m_own = 0;
    int          m_owner = 0, m_ptr = 0, m_cnt = 0;
    bit          m_en = 0, m_we = 0;
    logic [9:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_last = '0;
    bit          rv0 = 0, rv1 = 0;
    int          rid0 = 0, rid1 = 0;
    logic [31:0] rd0 = '0, rd1 = '0;
    logic [31:0] mm [int];

    int          fire_id[$], fire_cyc[$], rsp_cyc[$];
    logic [3:0]  rsp_oh[$];
    logic [31:0] rsp_dat[$];
    logic [3:0]  last_hs = '0;

    // Requester drivers
    int          rem [N];
    bit          we_c [N], lock_c [N];
    logic [9:0]  addr_c [N];
    logic [31:0] data_c [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mm_read(input logic [9:0] a);
        return mm.exists(int'(a)) ? mm[int'(a)] : pat(a);
    endfunction

    task automatic model_reset();
        m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_last = '0;
        rv0 = 0; rv1 = 0; rid0 = 0; rid1 = 0; rd0 = '0; rd1 = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (rem[i] > 0);
            req_we[i]             = we_c[i];
            req_lock[i]           = lock_c[i];
            req_addr[i*AW +: AW]  = addr_c[i];
            req_wdata[i*DW +: DW] = data_c[i];
        end
    endtask

    task automatic load(input int i, input int n, input bit we, input bit lock,
                        input logic [9:0] addr, input logic [31:0] data);
        rem[i] = n; we_c[i] = we; lock_c[i] = lock; addr_c[i] = addr; data_c[i] = data;
        drive();
    endtask

    // One clock: compare at negedge, advance model at posedge, update drivers after the edge.
    task automatic tick();
        logic [3:0]  e_ready, e_rspv;
        logic [31:0] e_rdata, f_wdata;
        logic [9:0]  f_addr;
        bit          fire, found, f_we;
        bit          n_own, n_en, n_we, n_rv0, n_rv1;
        int          n_owner, n_ptr, n_cnt, n_rid0, n_rid1, w;
        logic [9:0]  n_addr;
        logic [31:0] n_wdata, n_rd0, n_rd1, n_last;
        @(negedge clk);
        if (!rst_n) model_reset();
        e_ready = m_own ? (4'b1 << m_owner) : 4'b0;
        e_rspv  = rv1 ? (4'b1 << rid1) : 4'b0;
        e_rdata = rv1 ? rd1 : m_last;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("mem_en", 32'(mem_en), 32'(m_en));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("grant_id", 32'(grant_id), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_own | rv0 | rv1));
        if (rsp_valid != 0) begin
            rsp_cyc.push_back(cyc); rsp_oh.push_back(rsp_valid); rsp_dat.push_back(rsp_rdata);
        end
        last_hs = req_valid & req_ready;

        n_own = m_own; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
        fire    = rst_n && m_own && req_valid[m_owner];
        f_we    = req_we[m_owner];
        f_addr  = req_addr[m_owner*AW +: AW];
        f_wdata = req_wdata[m_owner*DW +: DW];
        n_en = fire; n_we = fire && f_we;
        n_addr  = fire ? f_addr : m_addr;
        n_wdata = fire ? f_wdata : m_wdata;
        n_rv1 = rv0; n_rid1 = rid0; n_rd1 = rd0;
        n_rv0 = fire && !f_we; n_rid0 = m_owner; n_rd0 = mm_read(f_addr);
        n_last = rv1 ? rd1 : m_last;
        if (fire) begin
            fire_id.push_back(m_owner); fire_cyc.push_back(cyc);
        end
        if (!m_own) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (!found && req_valid[w]) begin
                    found = 1; n_own = 1; n_owner = w; n_ptr = (w + 1) % N; n_cnt = 0;
                end
            end
        end else if (!req_valid[m_owner]) begin
            n_own = 0;
        end else if (!req_lock[m_owner] || m_cnt == MB - 1) begin
            n_own = 0;
        end else begin
            n_cnt = m_cnt + 1;
        end

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_own = n_own; m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt;
            m_en = n_en; m_we = n_we; m_addr = n_addr; m_wdata = n_wdata;
            rv0 = n_rv0; rv1 = n_rv1; rid0 = n_rid0; rid1 = n_rid1;
            rd0 = n_rd0; rd1 = n_rd1; m_last = n_last;
            if (fire && f_we) mm[int'(f_addr)] = f_wdata;
        end
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_hs[i]) begin
                rem[i]--; addr_c[i] = addr_c[i] + 10'd1; data_c[i] = data_c[i] + 32'd1;
            end
        end
        drive();
    endtask

    task automatic run_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!((rem[0] + rem[1] + rem[2] + rem[3]) == 0 && !m_own && !rv0 && !rv1)
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d cycles, required fewer than %0d", name, n, budget);
        end
        tick();
    endtask

    int f0, r0, c0, n;

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; we_c[i] = 0; lock_c[i] = 0; addr_c[i] = '0; data_c[i] = '0;
        end
        drive();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;

        // All four unlocked reads at once
        f0 = fire_id.size(); r0 = rsp_oh.size(); c0 = cyc;
        for (int i = 0; i < N; i++) load(i, 1, 0, 0, 10'(16 + i), 32'd0);
        run_idle("t1", 40);
        chk("t1_nfire", 32'(fire_id.size() - f0), 32'd4);
        chk("t1_nrsp", 32'(rsp_oh.size() - r0), 32'd4);
        if (fire_id.size() - f0 == 4 && rsp_oh.size() - r0 == 4) begin
            chk("t1_first_arb", 32'(fire_cyc[f0]), 32'(c0 + 1));
            for (int k = 0; k < 4; k++) begin
                chk("t1_order", 32'(fire_id[f0+k]), 32'(k));
                if (k > 0) chk("t1_gap", 32'(fire_cyc[f0+k] - fire_cyc[f0+k-1]), 32'd2);
                chk("t1_rsp_oh", 32'(rsp_oh[r0+k]), 32'(4'b0001 << k));
                chk("t1_rsp_lat", 32'(rsp_cyc[r0+k] - fire_cyc[f0+k]), 32'd2);
                chk("t1_rsp_data", rsp_dat[r0+k], 32'hA000_0010 + 32'(k));
            end
        end

        // Locked burst of 20 with a competing requester arriving mid-burst
        f0 = fire_id.size();
        load(2, 20, 0, 1, 10'h100, 32'd0);
        repeat (3) tick();
        load(0, 1, 0, 0, 10'h020, 32'd0);
        run_idle("t2", 80);
        chk("t2_nfire", 32'(fire_id.size() - f0), 32'd21);
        if (fire_id.size() - f0 == 21) begin
            for (int k = 0; k < 21; k++)
                chk("t2_order", 32'(fire_id[f0+k]), (k == 16) ? 32'd0 : 32'd2);
            chk("t2_burst_span", 32'(fire_cyc[f0+15] - fire_cyc[f0]), 32'd15);
            chk("t2_tail_span", 32'(fire_cyc[f0+20] - fire_cyc[f0+17]), 32'd3);
        end

        // Write then read back through another requester
        r0 = rsp_oh.size();
        load(3, 1, 1, 0, 10'h005, 32'hDEAD_BEEF);
        run_idle("t3w", 20);
        load(1, 1, 0, 0, 10'h005, 32'd0);
        run_idle("t3r", 20);
        chk("t3_nrsp", 32'(rsp_oh.size() - r0), 32'd1);
        if (rsp_oh.size() - r0 == 1) begin
            chk("t3_rsp_oh", 32'(rsp_oh[r0]), 32'h2);
            chk("t3_rsp_data", rsp_dat[r0], 32'hDEAD_BEEF);
        end

        // Response routes to the earlier reader after ownership has moved
        f0 = fire_id.size(); r0 = rsp_oh.size();
        load(0, 1, 0, 0, 10'h030, 32'd0);
        load(1, 1, 0, 0, 10'h031, 32'd0);
        run_idle("t4", 20);
        chk("t4_nrsp", 32'(rsp_oh.size() - r0), 32'd2);
        if (rsp_oh.size() - r0 == 2 && fire_id.size() - f0 == 2) begin
            chk("t4_fire_ids", 32'({fire_id[f0][3:0], fire_id[f0+1][3:0]}), 32'h01);
            chk("t4_grant_gap", 32'(fire_cyc[f0+1] - fire_cyc[f0]), 32'd2);
            chk("t4_rsp0_cyc", 32'(rsp_cyc[r0]), 32'(fire_cyc[f0+1]));
            chk("t4_rsp0_oh", 32'(rsp_oh[r0]), 32'h1);
            chk("t4_rsp0_data", rsp_dat[r0], 32'hA000_0030);
            chk("t4_rsp1_oh", 32'(rsp_oh[r0+1]), 32'h2);
        end

        // Reset while a read is in flight
        r0 = rsp_oh.size();
        load(0, 1, 0, 0, 10'h040, 32'd0);
        n = 0;
        while (!last_hs[0] && n < 20) begin tick(); n++; end
        chk("t5_fired", 32'(last_hs[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_mem_en", 32'(mem_en), 32'd0);
        chk("t5_mem_addr", 32'(mem_addr), 32'd0);
        chk("t5_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t5_no_rsp", 32'(rsp_oh.size() - r0), 32'd0);

        // Lone requester 1 streaming unlocked reads
        f0 = fire_id.size();
        load(1, 5, 0, 0, 10'h050, 32'd0);
        run_idle("t6", 40);
        chk("t6_nfire", 32'(fire_id.size() - f0), 32'd5);
        if (fire_id.size() - f0 == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t6_id", 32'(fire_id[f0+k]), 32'd1);
                if (k > 0) chk("t6_gap", 32'(fire_cyc[f0+k] - fire_cyc[f0+k-1]), 32'd2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
